conv_loop_cnt: RTL and testbench
================================

# conv_loop_cnt

Nested loop index generator for the convolution engine. It is the counterpart of the convolution controller: the controller drives `loop_en`, and this block steps the six loop indices `rr, cc, mm, nn, ii, jj` that the controller watches to detect inner-loop and layer completion. It also registers input-feature-map pixel coordinates for the datapath address logic.

## Interface
Parameters:
- `DATA_SIZE`: from the shared parameter include. Width of the configuration words.
- `LOOP_BIT`: from the shared parameter include. Width of each loop index.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous abort; zeroes all indices and drops `pix_vld`.
- `loop_en`  in  1  step enable, driven by the convolution controller.
- `N, K, R, C, M`  in  DATA_SIZE each  input channels, kernel size, output rows, output columns, output channels.
- `S`  in  DATA_SIZE  stride.
- `rr, cc, mm, nn, ii, jj`  out  LOOP_BIT each  registered loop indices.
- `inner_last`  out  1  combinational; high when `nn==N-1`, `ii==K-1` and `jj==K-1`.
- `pix_row, pix_col`  out  DATA_SIZE each  registered input coordinates `rr*S+ii` and `cc*S+jj`.
- `pix_vld`  out  1  registered; qualifies `pix_row` and `pix_col`.

## Operation
- Loop order, innermost first: `jj` (K), `ii` (K), `nn` (N), `mm` (M), `cc` (C), `rr` (R).
- On a cycle with `loop_en=1`:
  - `jj` increments.
  - When an index is at its last value it wraps to 0 and carries into the next outer index.
  - A carry out of `rr` wraps every index to 0; this is layer completion.
- On a cycle with `loop_en=0`: indices hold.
- Last-value test for each index is `idx+1 >= DIM`.
  - Compare in DATA_SIZE width, with the index zero-extended.
  - A dimension of 0 therefore behaves as 1: the index stays 0 and always carries.
- Configuration inputs are used live. They must be stable from the first `loop_en` of a layer until `rr, cc, mm` return to 0.
- The block does not check the stability of configuration inputs.
- `inner_last` and the controller's inner-loop-end condition are the same expression.
- At the edge that consumes the `inner_last` step, these happen together:
  - `jj, ii, nn` wrap to 0.
  - `mm` (or the next outer index with a carry) advances.
- In the following cycle, `rr==cc==mm==0` means the layer is complete.
- Pixel coordinates:
  - `pix_row` and `pix_col` are computed from the current indices and registered on every `loop_en=1` cycle.
  - Arithmetic is unsigned, truncated to DATA_SIZE.
  - `pix_vld` equals the registered `loop_en`.
- Reset and `clr`:
  - Both zero all indices, `pix_row`, `pix_col` and `pix_vld`.
  - `rst` has priority over `clr`.
  - `clr` has priority over `loop_en`.
  - Either one takes effect mid-layer; the step in that cycle is discarded.

## Timing
- Reset values: all indices 0, `pix_row=0`, `pix_col=0`, `pix_vld=0`, `inner_last` evaluated from the zero indices.
- Index latency: one cycle. The indices presented while `loop_en=1` are consumed, and the next set is visible after the edge.
- Coordinate latency:
  - `pix_*` for the indices consumed in cycle t appear in cycle t+1, with `pix_vld=1`.
  - `pix_vld` in cycle t+1 equals `loop_en` of cycle t.
- Bias gap: when `loop_en` is low for one cycle, the indices are frozen and `pix_vld` drops for exactly one cycle after.
- Steps per layer: R·C·M·N·K·K edges with `loop_en=1`. The indices then read all zero again.

## Structure
- Use `DATA_SIZE` and `LOOP_BIT` from the shared parameter include; no new package constants.
- One sub-module, `wrap_cnt`: a single index counter with enable, `dim`, `clr`, and a `carry` output.
  - Instantiate it six times.
  - Chain each counter's enable as `loop_en` AND all inner carries.
- The coordinate multiply-add lives in the top level.

## Test plan
- N=2, K=3, R=C=M=1, S=1, `loop_en` held high → after 18 steps the indices read all zero; `inner_last` is high exactly on step 18; `jj` reads 0,1,2,0,… .
- N=1, K=2, M=2, C=2, R=2, with the controller's one-cycle `loop_en` bias gap after each `inner_last` → 32 steps total; indices freeze during each gap; `rr,cc,mm` return to 0 only at the final wrap.
- S=2, K=3 at rr=1, cc=2 → `pix_row` = 2,2,2,3,3,3,4,4,4; `pix_col` = 4,5,6 repeating; `pix_vld` lags `loop_en` by one cycle.
- K=0, N=0, all other dimensions 1 → every step wraps to all zero; `inner_last` is constantly high.
- `clr` asserted mid-layer together with `loop_en=1` → next cycle all indices are 0 and `pix_vld=0`; the layer restarts cleanly.
- `rst` asserted while `loop_en=1` → all outputs take their reset values at the next edge; the counters do not move while reset is held.

Source files
------------

// File: rtl/conv_loop_cnt_pkg.sv
// Shared widths for the convolution loop counters and the last-value test
// used by every index counter.
package conv_loop_cnt_pkg;

  localparam int DATA_SIZE = 16;
  localparam int LOOP_BIT  = 8;

  // Dimension 0 behaves as 1: any index reads as its last value.
  function automatic logic idx_last(input logic [DATA_SIZE-1:0] idx_ext,
                                    input logic [DATA_SIZE-1:0] dim);
    logic [DATA_SIZE-1:0] nxt;
    nxt = idx_ext + 1'b1;
    return nxt >= dim;
  endfunction

endpackage

// File: rtl/wrap_cnt.sv
// One loop index: steps on en, wraps to 0 after its last value, and flags
// that last value on carry for the next outer counter.
module wrap_cnt
  import conv_loop_cnt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] dim,
  output logic [LOOP_BIT-1:0]  idx,
  output logic                 carry
);

  logic [LOOP_BIT-1:0] idx_q, idx_d;

  assign carry = idx_last({{(DATA_SIZE-LOOP_BIT){1'b0}}, idx_q}, dim);
  assign idx   = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr)
      idx_d = '0;
    else if (en)
      idx_d = carry ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/conv_loop_cnt.sv
// Six-deep nested loop index generator (jj innermost, rr outermost) with
// registered input-feature-map pixel coordinates.
module conv_loop_cnt
  import conv_loop_cnt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 loop_en,
  input  logic [DATA_SIZE-1:0] N,
  input  logic [DATA_SIZE-1:0] K,
  input  logic [DATA_SIZE-1:0] R,
  input  logic [DATA_SIZE-1:0] C,
  input  logic [DATA_SIZE-1:0] M,
  input  logic [DATA_SIZE-1:0] S,
  output logic [LOOP_BIT-1:0]  rr,
  output logic [LOOP_BIT-1:0]  cc,
  output logic [LOOP_BIT-1:0]  mm,
  output logic [LOOP_BIT-1:0]  nn,
  output logic [LOOP_BIT-1:0]  ii,
  output logic [LOOP_BIT-1:0]  jj,
  output logic                 inner_last,
  output logic [DATA_SIZE-1:0] pix_row,
  output logic [DATA_SIZE-1:0] pix_col,
  output logic                 pix_vld
);

  localparam int NLOOP = 6;

  // Slot order, innermost first: jj, ii, nn, mm, cc, rr.
  logic [NLOOP-1:0][DATA_SIZE-1:0] dim;
  logic [NLOOP-1:0][LOOP_BIT-1:0]  idx;
  logic [NLOOP-1:0]                carry;
  logic [NLOOP:0]                  en;

  assign dim = {R, C, M, N, K, K};
  assign en[0] = loop_en;

  for (genvar g = 0; g < NLOOP; g++) begin : g_cnt
    assign en[g+1] = en[g] & carry[g];
    wrap_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (en[g]),
      .dim   (dim[g]),
      .idx   (idx[g]),
      .carry (carry[g])
    );
  end

  assign jj = idx[0];
  assign ii = idx[1];
  assign nn = idx[2];
  assign mm = idx[3];
  assign cc = idx[4];
  assign rr = idx[5];

  // Same expression the controller uses for its inner-loop end.
  assign inner_last = carry[0] & carry[1] & carry[2];

  logic [DATA_SIZE-1:0] pix_row_q, pix_row_d;
  logic [DATA_SIZE-1:0] pix_col_q, pix_col_d;
  logic                 pix_vld_q, pix_vld_d;

  always_comb begin
    pix_row_d = pix_row_q;
    pix_col_d = pix_col_q;
    pix_vld_d = loop_en;
    if (clr) begin
      pix_row_d = '0;
      pix_col_d = '0;
      pix_vld_d = 1'b0;
    end else if (loop_en) begin
      pix_row_d = DATA_SIZE'(rr) * S + DATA_SIZE'(ii);
      pix_col_d = DATA_SIZE'(cc) * S + DATA_SIZE'(jj);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_row_q <= '0;
      pix_col_q <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
      pix_vld_q <= pix_vld_d;
    end
  end

  assign pix_row = pix_row_q;
  assign pix_col = pix_col_q;
  assign pix_vld = pix_vld_q;

endmodule

// File: tb/tb_conv_loop_cnt.sv
// Directed bench for conv_loop_cnt: a vector table for the pixel/clr path plus
// hand-written sequences for full-layer, bias-gap, degenerate and reset cases.
module tb_conv_loop_cnt;
  import conv_loop_cnt_pkg::*;

  logic clk = 1'b0;
  logic rst, clr, loop_en;
  logic [DATA_SIZE-1:0] N, K, R, C, M, S;
  logic [LOOP_BIT-1:0] rr, cc, mm, nn, ii, jj;
  logic inner_last, pix_vld;
  logic [DATA_SIZE-1:0] pix_row, pix_col;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_loop_cnt dut (
    .clk(clk), .rst(rst), .clr(clr), .loop_en(loop_en),
    .N(N), .K(K), .R(R), .C(C), .M(M), .S(S),
    .rr(rr), .cc(cc), .mm(mm), .nn(nn), .ii(ii), .jj(jj),
    .inner_last(inner_last), .pix_row(pix_row), .pix_col(pix_col),
    .pix_vld(pix_vld)
  );

  typedef struct {
    logic        clr;
    logic        en;
    logic [47:0] idx;   // {rr,cc,mm,nn,ii,jj}
    logic        il;
    logic        vld;
    logic [15:0] row;
    logic [15:0] col;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic c, input logic e,
                              input int r, input int cl, input int i, input int j,
                              input logic il, input logic v,
                              input int row, input int col);
    vec_t t;
    t.clr = c; t.en = e;
    t.idx = {8'(r), 8'(cl), 8'd0, 8'd0, 8'(i), 8'(j)};
    t.il = il; t.vld = v; t.row = 16'(row); t.col = 16'(col);
    return t;
  endfunction

  function automatic logic [47:0] pk(input int r, input int c, input int m,
                                     input int n, input int i, input int j);
    return {8'(r), 8'(c), 8'(m), 8'(n), 8'(i), 8'(j)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic e);
    clr = c; loop_en = e;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic cfg(input int n, input int k, input int r, input int c,
                     input int m, input int s);
    N = 16'(n); K = 16'(k); R = 16'(r); C = 16'(c); M = 16'(m); S = 16'(s);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; loop_en = 1'b0;
    cfg(2, 3, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idx", {16'd0, rr, cc, mm, nn, ii, jj}, 64'd0);
    chk("reset_pix", {31'd0, pix_vld, pix_row, pix_col}, 64'd0);
    chk("reset_il", 64'(inner_last), 64'd0);
    rst = 1'b0;

    // N=2,K=3: 18 steps per layer, jj cycles 0,1,2
    for (int s = 0; s < 18; s++) begin
      chk("l1_idx", 64'({rr, cc, mm, nn, ii, jj}), 64'(pk(0, 0, 0, s / 9, (s / 3) % 3, s % 3)));
      chk("l1_il", 64'(inner_last), 64'(s == 17));
      step(1'b0, 1'b1);
    end
    chk("l1_wrap", 64'({rr, cc, mm, nn, ii, jj}), 64'd0);

    // N=1,K=2,M=C=R=2 with a one-cycle bias gap after each inner_last
    cfg(1, 2, 2, 2, 2, 1);
    step(1'b1, 1'b0);
    for (int s = 0; s < 32; s++) begin
      chk("l2_idx", 64'({rr, cc, mm, nn, ii, jj}),
          64'(pk((s / 16) % 2, (s / 8) % 2, (s / 4) % 2, 0, (s / 2) % 2, s % 2)));
      chk("l2_il", 64'(inner_last), 64'(s % 4 == 3));
      step(1'b0, 1'b1);
      if (s % 4 == 3) begin
        step(1'b0, 1'b0);
        chk("l2_gap_idx", 64'({rr, cc, mm, nn, ii, jj}),
            64'(pk(((s + 1) / 16) % 2, ((s + 1) / 8) % 2, ((s + 1) / 4) % 2, 0, 0, 0)));
        chk("l2_gap_vld", 64'(pix_vld), 64'd0);
      end
    end
    chk("l2_wrap", 64'({rr, cc, mm, nn, ii, jj}), 64'd0);

    // S=2,K=3: walk to rr=1,cc=2 then apply the table
    cfg(1, 3, 2, 3, 1, 2);
    step(1'b1, 1'b0);
    repeat (45) step(1'b0, 1'b1);
    chk("l3_pos", 64'({rr, cc, mm, nn, ii, jj}), 64'(pk(1, 2, 0, 0, 0, 0)));

    tbl[0]  = mk(0, 1, 1, 2, 0, 1, 0, 1, 2, 4);
    tbl[1]  = mk(0, 1, 1, 2, 0, 2, 0, 1, 2, 5);
    tbl[2]  = mk(0, 1, 1, 2, 1, 0, 0, 1, 2, 6);
    tbl[3]  = mk(0, 1, 1, 2, 1, 1, 0, 1, 3, 4);
    tbl[4]  = mk(0, 1, 1, 2, 1, 2, 0, 1, 3, 5);
    tbl[5]  = mk(0, 1, 1, 2, 2, 0, 0, 1, 3, 6);
    tbl[6]  = mk(0, 1, 1, 2, 2, 1, 0, 1, 4, 4);
    tbl[7]  = mk(0, 1, 1, 2, 2, 2, 1, 1, 4, 5);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 4, 6);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 6);
    tbl[10] = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int v = 0; v < 13; v++) begin
      step(tbl[v].clr, tbl[v].en);
      chk($sformatf("tbl%0d_idx", v), 64'({rr, cc, mm, nn, ii, jj}), 64'(tbl[v].idx));
      chk($sformatf("tbl%0d_il", v), 64'(inner_last), 64'(tbl[v].il));
      chk($sformatf("tbl%0d_pix", v), 64'({pix_vld, pix_row, pix_col}),
          64'({tbl[v].vld, tbl[v].row, tbl[v].col}));
    end

    // K=0,N=0: every step wraps to zero, inner_last always high
    cfg(0, 0, 1, 1, 1, 1);
    step(1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      chk("deg_il", 64'(inner_last), 64'd1);
      step(1'b0, 1'b1);
      chk("deg_idx", 64'({rr, cc, mm, nn, ii, jj}), 64'd0);
    end

    // rst while stepping: reset values, no movement while held
    cfg(2, 3, 1, 1, 1, 1);
    repeat (4) step(1'b0, 1'b1);
    chk("pre_rst_idx", 64'({rr, cc, mm, nn, ii, jj}), 64'(pk(0, 0, 0, 0, 1, 1)));
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 1'b1);
      chk("rst_idx", 64'({rr, cc, mm, nn, ii, jj}), 64'd0);
      chk("rst_pix", 64'({pix_vld, pix_row, pix_col}), 64'd0);
    end
    rst = 1'b0;
    step(1'b0, 1'b1);
    chk("post_rst", 64'({rr, cc, mm, nn, ii, jj, 7'd0, pix_vld}), 64'({pk(0, 0, 0, 0, 0, 1), 8'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
